axil_master: RTL
================

Name: axil_master

Overview:
- Single-outstanding AXI-Lite initiator (manager) that converts a simple command/response handshake into AXI-Lite read and write transactions.
- Sits between control logic (sequencers, test harnesses, register loaders) and any AXI-Lite responder, such as our RAM and register blocks.
- 32-bit data only.
- One transaction in flight at a time; AW and W issued concurrently.

Parameters:
- ADDR_W, 32, AXI-Lite and command address width in bits (min 3).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- cmdValid  in  1  command valid.
- cmdReady  out  1  command accepted when high with cmdValid.
- cmdWrite  in  1  1 = write, 0 = read.
- cmdAddr  in  ADDR_W  byte address.
- cmdData  in  32  write data.
- cmdStrb  in  4  write byte strobes; ignored for reads.
- rspValid  out  1  response valid.
- rspReady  in  1  response consumed.
- rspData  out  32  read data; 0 for writes.
- rspResp  out  2  bResp or rResp of the transaction.
- awValid, awReady  out, in  1  write address handshake.
- awAddr  out  ADDR_W  write address.
- awProt  out  3  constant 3'b000.
- wValid, wReady  out, in  1  write data handshake.
- wData  out  32  write data.
- wStrb  out  4  write strobes.
- bValid, bReady  in, out  1  write response handshake.
- bResp  in  2  write response.
- arValid, arReady  out, in  1  read address handshake.
- arAddr  out  ADDR_W  read address.
- arProt  out  3  constant 3'b000.
- rValid, rReady  in, out  1  read data handshake.
- rData  in  32  read data.
- rResp  in  2  read response.

Behaviour:
- All outputs are registered.
- Reset values (while aresetn=0 at posedge): every valid/ready output 0, cmdReady 0, address/data/strb outputs 0, rspData 0, rspResp 0, FSM in IDLE.
- cmdReady goes 1 on the first clock edge after aresetn is sampled high.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE (cmdReady=1). On cmdValid&&cmdReady at edge N, capture addr/data/strb and drop cmdReady.
  - Write: go to WR_REQ; awValid=wValid=1 from N+1.
  - Read: go to RD_REQ; arValid=1 from N+1.
- WR_REQ:
  - awValid drops on the edge where awValid&&awReady; wValid drops on the edge where wValid&&wReady. The two are independent; either order or the same cycle is allowed.
  - Once both handshakes are complete, move to WR_RESP and raise bReady on that same edge.
  - bReady is never high before both handshakes are complete.
- WR_RESP: on bValid&&bReady, drop bReady, set rspResp=bResp, rspData=0, rspValid=1, and go to RSP.
- RD_REQ: on arValid&&arReady, drop arValid, raise rReady, and go to RD_RESP.
- RD_RESP: on rValid&&rReady, drop rReady, capture rspData=rData and rspResp=rResp, set rspValid=1, and go to RSP.
- RSP:
  - rspValid, rspData and rspResp are held stable until rspValid&&rspReady.
  - On that handshake edge: rspValid goes 0, cmdReady goes 1, and the FSM returns to IDLE.
- Latency with zero-wait responder and rspReady held high:
  - Write: cmd edge N, AW/W handshake at N+1, B handshake at N+2, rspValid at N+3, cmdReady at N+4.
  - Read: AR handshake at N+1, R handshake at N+2, rspValid at N+3.
- Protocol rules:
  - No valid is withdrawn before its handshake.
  - awAddr/wData/wStrb/arAddr are held stable while the corresponding valid is high.
  - bValid/rValid arriving in states other than WR_RESP/RD_RESP are ignored; ready is low there.
- Non-OKAY responses (2'b10, 2'b11) are passed through to rspResp unchanged; no retry.
- Reset mid-transaction: abandon the transaction and return to reset values. The responder shares aresetn.

Optional Feature:
- Macro: AXIL_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A command with cmdAddr[1:0]!=0 issues no bus activity; all AXI valids stay 0.
  - The edge after acceptance sets rspValid=1, rspResp=2'b10 (SLVERR), rspData=0, and the FSM goes to RSP.
  - Aligned commands behave as normal.
- Undefined: no check; awAddr/arAddr carry the full cmdAddr unchanged, including the low bits.

Test Plan:
- Write cmdAddr=0x10, cmdData=0xDEADBEEF, cmdStrb=4'hF to a zero-wait RAM responder -> one AW and one W beat with awAddr=0x10; rspResp=0, rspData=0; rspValid exactly 3 cycles after the cmd edge.
- Read back 0x10 -> arAddr=0x10, rspData=0xDEADBEEF, rspResp=0.
- Responder stalls awReady 5 cycles but accepts W immediately -> wValid drops after 1 cycle; awValid held with stable awAddr; bReady stays 0 until the AW handshake.
- Responder returns rResp=2'b10, rData=0x12345678 -> rspResp=2'b10, rspData=0x12345678; rspReady held low 4 cycles -> rsp outputs stable and cmdReady=0 throughout.
- aresetn driven low while in WR_REQ -> next edge all valids/readies are 0; cmdReady=1 the edge after aresetn returns high; a following read of 0x0 completes normally.
- With AXIL_MASTER_ALIGN_CHECK_EN defined, write to 0x13 -> no awValid/wValid; rspResp=2'b10 one cycle after acceptance. Without the macro -> awAddr=0x13 is issued.

Source files
------------

// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI-Lite manager that turns a cmd/rsp handshake into AW+W/B or AR/R.
// Latency: with a zero-wait responder and rspReady high, the edge after acceptance+3 samples rspValid and +4 samples cmdReady.
// Backpressure: cmdReady stays low while a transaction is open; each bus valid is held until its ready; rsp is held until rspReady.
// Option: define AXIL_MASTER_ALIGN_CHECK_EN to answer unaligned cmdAddr with SLVERR and no bus activity.
module axil_master #(
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  // command side
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWrite,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [31:0]       cmdData,
  input  logic [3:0]        cmdStrb,
  // response side
  output logic              rspValid,
  input  logic              rspReady,
  output logic [31:0]       rspData,
  output logic [1:0]        rspResp,
  // write address
  output logic              awValid,
  input  logic              awReady,
  output logic [ADDR_W-1:0] awAddr,
  output logic [2:0]        awProt,
  // write data
  output logic              wValid,
  input  logic              wReady,
  output logic [31:0]       wData,
  output logic [3:0]        wStrb,
  // write response
  input  logic              bValid,
  output logic              bReady,
  input  logic [1:0]        bResp,
  // read address
  output logic              arValid,
  input  logic              arReady,
  output logic [ADDR_W-1:0] arAddr,
  output logic [2:0]        arProt,
  // read data
  input  logic              rValid,
  output logic              rReady,
  input  logic [31:0]       rData,
  input  logic [1:0]        rResp
);

  // ALN_ERR is only reachable when the alignment check is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5,
    ALN_ERR = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_rdy_q, cmd_rdy_d;
  logic                aw_vld_q, aw_vld_d;
  logic                w_vld_q, w_vld_d;
  logic                b_rdy_q, b_rdy_d;
  logic                ar_vld_q, ar_vld_d;
  logic                r_rdy_q, r_rdy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          strb_q, strb_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [31:0]         rsp_dat_q, rsp_dat_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  // Next-state and registered-output logic; every register holds by default.
  always_comb begin
    state_d    = state_q;
    cmd_rdy_d  = cmd_rdy_q;
    aw_vld_d   = aw_vld_q;
    w_vld_d    = w_vld_q;
    b_rdy_d    = b_rdy_q;
    ar_vld_d   = ar_vld_q;
    r_rdy_d    = r_rdy_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_resp_d = rsp_resp_q;

    case (state_q)
      IDLE: begin
        // cmdReady rises on the first edge out of reset and stays up while idle.
        cmd_rdy_d = 1'b1;
        if (cmdValid && cmd_rdy_q) begin
          cmd_rdy_d = 1'b0;
          addr_d    = cmdAddr;
          data_d    = cmdData;
          strb_d    = cmdStrb;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
          if (cmdAddr[1:0] != 2'b00) begin
            state_d = ALN_ERR;
          end else
`endif
          if (cmdWrite) begin
            state_d  = WR_REQ;
            aw_vld_d = 1'b1;
            w_vld_d  = 1'b1;
          end else begin
            state_d  = RD_REQ;
            ar_vld_d = 1'b1;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; B is only accepted once both are gone.
        aw_vld_d = aw_vld_q && !awReady;
        w_vld_d  = w_vld_q && !wReady;
        if (!aw_vld_d && !w_vld_d) begin
          state_d = WR_RESP;
          b_rdy_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (bValid && b_rdy_q) begin
          b_rdy_d    = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_dat_d  = 32'h0;
          rsp_resp_d = bResp;
          state_d    = RSP;
        end
      end

      RD_REQ: begin
        if (ar_vld_q && arReady) begin
          ar_vld_d = 1'b0;
          r_rdy_d  = 1'b1;
          state_d  = RD_RESP;
        end
      end

      RD_RESP: begin
        if (rValid && r_rdy_q) begin
          r_rdy_d    = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_dat_d  = rData;
          rsp_resp_d = rResp;
          state_d    = RSP;
        end
      end

      RSP: begin
        if (rsp_vld_q && rspReady) begin
          rsp_vld_d = 1'b0;
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end
      end

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
      ALN_ERR: begin
        // Unaligned command: answer SLVERR without touching the bus.
        rsp_vld_d  = 1'b1;
        rsp_dat_d  = 32'h0;
        rsp_resp_d = 2'b10;
        state_d    = RSP;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cmd_rdy_q  <= 1'b0;
      aw_vld_q   <= 1'b0;
      w_vld_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
      ar_vld_q   <= 1'b0;
      r_rdy_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'h0;
      strb_q     <= 4'h0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= 32'h0;
      rsp_resp_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cmd_rdy_q  <= cmd_rdy_d;
      aw_vld_q   <= aw_vld_d;
      w_vld_q    <= w_vld_d;
      b_rdy_q    <= b_rdy_d;
      ar_vld_q   <= ar_vld_d;
      r_rdy_q    <= r_rdy_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end

  assign cmdReady = cmd_rdy_q;
  assign rspValid = rsp_vld_q;
  assign rspData  = rsp_dat_q;
  assign rspResp  = rsp_resp_q;
  assign awValid  = aw_vld_q;
  assign awAddr   = addr_q;
  assign awProt   = 3'b000;
  assign wValid   = w_vld_q;
  assign wData    = data_q;
  assign wStrb    = strb_q;
  assign bReady   = b_rdy_q;
  assign arValid  = ar_vld_q;
  assign arAddr   = addr_q;
  assign arProt   = 3'b000;
  assign rReady   = r_rdy_q;

endmodule
